// File: rtl/pipelined_mul_unit.sv
// Fully pipelined RV32M/RV64M multiply unit with tag tracking, global stall and flush.
// The product is formed at the input and carried through LATENCY stages so retiming can spread it.
module pipelined_mul_unit #(
    parameter int XLEN    = 32,
    parameter int LATENCY = 5,
    parameter int TAG_W   = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   in_op,
    input  logic [XLEN-1:0]              in_a,
    input  logic [XLEN-1:0]              in_b,
    input  logic [TAG_W-1:0]             in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              out_data,
    output logic [TAG_W-1:0]             out_tag,
    output logic [$clog2(LATENCY+1)-1:0] inflight
);

    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    logic              stall;
    logic              accept;
    logic              retire;
    logic              sign_a;
    logic              sign_b;
    logic [2*XLEN-1:0] a_wide;
    logic [2*XLEN-1:0] b_wide;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   result;

    logic              stg_valid [LATENCY];
    logic [XLEN-1:0]   stg_data  [LATENCY];
    logic [TAG_W-1:0]  stg_tag   [LATENCY];

    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign accept    = in_valid & in_ready & ~flush;
    assign retire    = out_valid & out_ready;

    assign out_valid = stg_valid[LATENCY-1];
    assign out_data  = stg_data[LATENCY-1];
    assign out_tag   = stg_tag[LATENCY-1];

    // Extending both operands to 2*XLEN and multiplying modulo 2^(2*XLEN) yields
    // the low 2*XLEN bits of the signed (XLEN+1)x(XLEN+1) product.
    always_comb begin
        sign_a  = ((in_op == OP_MULH) || (in_op == OP_MULHSU)) && in_a[XLEN-1];
        sign_b  = (in_op == OP_MULH) && in_b[XLEN-1];
        a_wide  = {{XLEN{sign_a}}, in_a};
        b_wide  = {{XLEN{sign_b}}, in_b};
        product = a_wide * b_wide;
        result  = (in_op == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stg_valid[i] <= 1'b0;
                stg_data[i]  <= '0;
                stg_tag[i]   <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < LATENCY; i++) begin
                stg_valid[i] <= 1'b0;
            end
        end else if (!stall) begin
            stg_valid[0] <= accept;
            stg_data[0]  <= result;
            stg_tag[0]   <= in_tag;
            for (int i = 1; i < LATENCY; i++) begin
                stg_valid[i] <= stg_valid[i-1];
                stg_data[i]  <= stg_data[i-1];
                stg_tag[i]   <= stg_tag[i-1];
            end
        end
    end

    // Simultaneous accept and retire leave the occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            inflight <= '0;
        end else if (accept && !retire) begin
            inflight <= inflight + CW'(1);
        end else if (!accept && retire) begin
            inflight <= inflight - CW'(1);
        end
    end

endmodule

// File: tb/tb_pipelined_mul_unit.sv
// Scoreboard bench for pipelined_mul_unit: directed vectors push expected results,
// an independent monitor retires them against the DUT output stream.
module tb_pipelined_mul_unit;

    localparam int XLEN    = 32;
    localparam int LATENCY = 5;
    localparam int TAG_W   = 5;
    localparam int NVEC    = 15;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [XLEN-1:0]   in_a;
    logic [XLEN-1:0]   in_b;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_data;
    logic [TAG_W-1:0]  out_tag;
    logic [$clog2(LATENCY+1)-1:0] inflight;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;

    logic             rand_ready = 1'b0;
    logic             prev_stall = 1'b0;
    logic [XLEN-1:0]  prev_data;
    logic [TAG_W-1:0] prev_tag;

    logic [1:0]       v_op  [NVEC];
    logic [XLEN-1:0]  v_a   [NVEC];
    logic [XLEN-1:0]  v_b   [NVEC];
    logic [XLEN-1:0]  v_exp [NVEC];

    pipelined_mul_unit #(.XLEN(XLEN), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .inflight  (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Called just after a rising edge; holds the op until the DUT takes it.
    task automatic applyStimulus(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                 input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] expected);
        bit accepted = 1'b0;
        int c = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        while (!accepted && c < 100) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back('{tag: tag, data: expected});
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
            c++;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: tag %0d never accepted", tag);
        end
    endtask

    task automatic waitDrain();
        int c = 0;
        while (exp_q.size() != 0 && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Starts right after the accept edge of a lone op with out_ready held high.
    task automatic measureLatency();
        int k = 1;
        @(negedge clk);
        checkOutput("inflight_after_accept", 64'(inflight), 64'(1));
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        checkOutput("latency", 64'(k), 64'(LATENCY));
        @(negedge clk);
        checkOutput("inflight_after_retire", 64'(inflight), 64'(0));
        checkOutput("out_valid_after_retire", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input int i, input logic [1:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] e);
        v_op[i]  = op;
        v_a[i]   = a;
        v_b[i]   = b;
        v_exp[i] = e;
    endtask

    // Monitor: retires results against the scoreboard and checks stall stability.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                checkOutput("stall_valid", 64'(out_valid), 64'(1));
                checkOutput("stall_data", 64'(out_data), 64'(prev_data));
                checkOutput("stall_tag", 64'(out_tag), 64'(prev_tag));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_result: tag %0d data 0x%0h, required none", out_tag, out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("result_tag", 64'(out_tag), 64'(mon_e.tag));
                    checkOutput("result_data", 64'(out_data), 64'(mon_e.data));
                end
            end
            checkOutput("inflight_bound", 64'(inflight <= LATENCY), 64'(1));
        end
        prev_stall = out_valid && !out_ready && !rst && !flush;
        prev_data  = out_data;
        prev_tag   = out_tag;
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        addVec(0,  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        addVec(1,  2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        addVec(2,  2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        addVec(3,  2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
        addVec(4,  2'b01, 32'h80000000, 32'h80000000, 32'h40000000);
        addVec(5,  2'b00, 32'h12345678, 32'h00000010, 32'h23456780);
        addVec(6,  2'b11, 32'h80000000, 32'h00000002, 32'h00000001);
        addVec(7,  2'b01, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF);
        addVec(8,  2'b10, 32'h80000000, 32'h80000000, 32'hC0000000);
        addVec(9,  2'b11, 32'h80000000, 32'h80000000, 32'h40000000);
        addVec(10, 2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF);
        addVec(11, 2'b10, 32'h00000003, 32'hFFFFFFFF, 32'h00000002);
        addVec(12, 2'b01, 32'hFFFFFFFF, 32'h80000000, 32'h00000000);
        addVec(13, 2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE);
        addVec(14, 2'b10, 32'h00000002, 32'h80000000, 32'h00000001);

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
        checkOutput("reset_out_data", 64'(out_data), 64'(0));
        checkOutput("reset_out_tag", 64'(out_tag), 64'(0));
        checkOutput("reset_inflight", 64'(inflight), 64'(0));
        checkOutput("reset_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        $display("[TB] single MUL latency");
        applyStimulus(2'b00, 32'd7, 32'd6, 5'd3, 32'h0000002A);
        measureLatency();

        $display("[TB] directed arithmetic vectors");
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(v_op[i], v_a[i], v_b[i], 5'(i + 16), v_exp[i]);
        end
        waitDrain();

        $display("[TB] back-pressure with tags 1..5");
        for (int t = 1; t <= 5; t++) begin
            applyStimulus(2'b00, 32'(t), 32'd10, 5'(t), 32'(t * 10));
        end
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checkOutput("stalled_in_ready", 64'(in_ready), 64'(0));
            checkOutput("stalled_out_tag", 64'(out_tag), 64'(1));
            checkOutput("stalled_out_data", 64'(out_data), 64'(10));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        waitDrain();

        $display("[TB] flush with op presented");
        for (int t = 6; t <= 8; t++) begin
            applyStimulus(2'b00, 32'(t), 32'd3, 5'(t), 32'(t * 3));
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_a     = 32'd9;
        in_b     = 32'd9;
        in_tag   = 5'd9;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checkOutput("flush_inflight", 64'(inflight), 64'(0));
        checkOutput("flush_out_valid", 64'(out_valid), 64'(0));
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;

        $display("[TB] reset with ops in flight");
        out_ready = 1'b0;
        for (int t = 10; t <= 13; t++) begin
            applyStimulus(2'b11, 32'(t), 32'hFFFFFFFF, 5'(t), 32'(t - 1));
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_out_data", 64'(out_data), 64'(0));
        checkOutput("rst_out_tag", 64'(out_tag), 64'(0));
        checkOutput("rst_inflight", 64'(inflight), 64'(0));
        checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(2'b01, 32'hFFFFFFFE, 32'h00000003, 5'd21, 32'hFFFFFFFF);
        measureLatency();

        $display("[TB] vectors with random back-pressure and gaps");
        rand_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NVEC; i++) begin
                applyStimulus(v_op[i], v_a[i], v_b[i], 5'(i + r * 16), v_exp[i]);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        waitDrain();
        repeat (6) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
